// File: rtl/seq_divider.sv
// Unsigned N-bit sequential divider using the non-restoring algorithm.
// A control FSM (IDLE/LOAD/ITER/FIX/DONE) sequences a shift/add-subtract
// datapath. It produces quotient and remainder after N iterations. A zero
// divisor skips the iterations and flags div_by_zero.
module seq_divider #(
    parameter int N     = 8,
    parameter int alpha = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] data_inQ,
    input  logic [N-1:0] data_inM,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_by_zero,
    output logic [2:0]   state
);

    localparam int CW = alpha + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    // The datapath values for one iteration and for the final correction.
    // A is signed, so its top bit chooses between subtracting and adding M back.
    logic [N:0] shifted_a;
    logic [N:0] iter_a;
    logic [N:0] fixed_a;

    // Datapath arithmetic for the current cycle. All sums wrap modulo 2^(N+1).
    always_comb begin
        shifted_a = {a_q[N-1:0], q_q[N-1]};
        iter_a    = a_q[N] ? (shifted_a + {1'b0, m_q}) : (shifted_a - {1'b0, m_q});
        fixed_a   = a_q[N] ? (a_q + {1'b0, m_q}) : a_q;
    end

    // Next-state and register-update decode for the FSM and datapath.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d     = '0;
                q_d     = data_inQ;
                m_d     = data_inM;
                count_d = CW'(N);
                dbz_d   = 1'b0;
                if (data_inM == '0) begin
                    // A zero divisor goes straight to DONE with a saturated quotient.
                    quotient_d  = '1;
                    remainder_d = data_inQ;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d     = iter_a;
                q_d     = {q_q[N-2:0], ~iter_a[N]};
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A negative partial remainder needs one final restore.
                a_d         = fixed_a;
                quotient_d  = q_q;
                remainder_d = fixed_a[N-1:0];
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign state       = state_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. Expected results are pushed to a
// scoreboard when a divide is launched and popped when done pulses.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_inQ;
    logic [7:0] data_inM;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       done;
    logic       busy;
    logic       div_by_zero;
    logic [2:0] state;

    seq_divider #(.N(8), .alpha(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_inQ   (data_inQ),
        .data_inM   (data_inM),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    int check_count = 0;
    int error_count = 0;

    logic [7:0] last_q;
    logic [7:0] last_r;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Build the expected result from the operands alone.
    task automatic push_expect(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.lat = 2;
        end else begin
            e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 11;
        end
        sb.push_back(e);
    endtask

    // Wait (bounded) for done; cyc counts negedges since the start edge.
    task automatic wait_done(input string tag, inout int cyc, output bit got);
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check_val({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (done) got = 1'b1;
        end
        check_val({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic compare_result(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_val({tag, "_quot"}, 32'(quotient), 32'(e.q));
        check_val({tag, "_rem"}, 32'(remainder), 32'(e.r));
        check_val({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        check_val({tag, "_lat"}, 32'(lat), 32'(e.lat));
        last_q = quotient;
        last_r = remainder;
        $display("div %s: q=%0d r=%0d dbz=%0d latency=%0d", tag, quotient, remainder, div_by_zero, lat);
    endtask

    // Launch one divide from IDLE and check its result and the done pulse width.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input string tag);
        int cyc;
        bit got;
        push_expect(a, b);
        @(negedge clk);
        data_inQ = a;
        data_inM = b;
        start    = 1'b1;
        @(posedge clk);
        cyc = 0;
        wait_done(tag, cyc, got);
        if (got) begin
            compare_result(tag, cyc);
            @(negedge clk);
            check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
            check_val({tag, "_idle"}, 32'(state), 32'd0);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int  cyc;
        int  first_done;
        int  ncyc;
        bit  got;
        bit  seen_done;
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n    = 1'b0;
        start    = 1'b0;
        data_inQ = 8'd0;
        data_inM = 8'd0;
        last_q   = 8'd0;
        last_r   = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_quot", 32'(quotient), 32'd0);
        check_val("rst_rem", 32'(remainder), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        // Basic and boundary operand patterns.
        run_div(8'd39, 8'd31, "39/31");
        run_div(8'd255, 8'd1, "255/1");
        run_div(8'd255, 8'd255, "255/255");
        run_div(8'd0, 8'd7, "0/7");
        run_div(8'd7, 8'd9, "7/9");
        run_div(8'd100, 8'd0, "100/0");
        run_div(8'd100, 8'd10, "100/10");

        // Reset in the middle of a divide abandons it without a done.
        @(negedge clk);
        data_inQ = 8'd200;
        data_inM = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("midrst_in_iter", 32'(state), 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_state", 32'(state), 32'd0);
        check_val("midrst_quot", 32'(quotient), 32'd0);
        check_val("midrst_rem", 32'(remainder), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check_val("midrst_no_done", 32'(seen_done), 32'd0);
        run_div(8'd200, 8'd3, "200/3");

        // start held high: operands changed mid-divide, then back-to-back.
        push_expect(8'd39, 8'd31);
        push_expect(8'd50, 8'd7);
        @(negedge clk);
        data_inQ = 8'd39;
        data_inM = 8'd31;
        start    = 1'b1;
        @(posedge clk);
        ncyc = 0;
        first_done = 0;
        got = 1'b0;
        while (!got && ncyc < 40) begin
            @(negedge clk);
            ncyc++;
            if (ncyc == 3) begin
                data_inQ = 8'd50;
                data_inM = 8'd7;
            end
            if (done) got = 1'b1;
        end
        check_val("b2b_first_timeout", 32'(got), 32'd1);
        if (got) begin
            first_done = ncyc;
            compare_result("b2b_first", ncyc);
            @(negedge clk);
            ncyc++;
            check_val("b2b_gap_idle", 32'(state), 32'd0);
            @(negedge clk);
            ncyc++;
            start = 1'b0;
            check_val("b2b_second_load", 32'(state), 32'd1);
            got = 1'b0;
            while (!got && ncyc < 80) begin
                @(negedge clk);
                ncyc++;
                if (done) got = 1'b1;
            end
            check_val("b2b_second_timeout", 32'(got), 32'd1);
            if (got) begin
                compare_result("b2b_second", ncyc - first_done - 1);
                check_val("b2b_spacing", 32'(ncyc - first_done), 32'd12);
            end
            @(negedge clk);
        end
        start = 1'b0;
        sb.delete();

        // Random operand pairs: model comparison plus the division invariant.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            run_div(ra, rb, $sformatf("rnd%0d_%0d/%0d", i, ra, rb));
            check_val("rnd_invariant", 32'(last_q) * 32'(rb) + 32'(last_r), 32'(ra));
            check_val("rnd_rem_lt_div", 32'(last_r < rb), 32'd1);
        end

        cyc = 0;
        cyc = cyc + 0;
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
